// File: rtl/spi_responder_if.sv
// Bus bundle for spi_responder: SPI frame pins, user-side register port and
// SPI write/status reporting. The responder connects through the slave modport.
interface spi_responder_if;
   logic       SPI_EN;
   logic       SPI_CLK;
   logic       SPI_IN;
   logic       SPI_OUT;
   logic [6:0] usr_addr;
   logic [7:0] usr_rdata;
   logic       usr_we;
   logic [7:0] usr_wdata;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       frame_err;

   modport master (
      output SPI_EN, SPI_CLK, SPI_IN, usr_addr, usr_we, usr_wdata,
      input  SPI_OUT, usr_rdata, wr_valid, wr_addr, wr_data, busy, frame_err
   );

   modport slave (
      input  SPI_EN, SPI_CLK, SPI_IN, usr_addr, usr_we, usr_wdata,
      output SPI_OUT, usr_rdata, wr_valid, wr_addr, wr_data, busy, frame_err
   );
endinterface

// File: rtl/spi_responder.sv
// SPI register-file responder: decodes 16-bit mode/address/data frames clocked
// in the FSM_Clk domain and shares its register array with a user-side port.
module spi_responder #(
   parameter int unsigned NUM_REGS = 128,
   parameter logic [7:0]  INIT_VAL = 8'h00
) (
   input  logic           FSM_Clk,
   input  logic           reset,
   spi_responder_if.slave bus
);
   localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t     state;
   logic [7:0] regs [NUM_REGS];
   logic       clk_q;
   logic       rise;
   logic       mode;
   logic [2:0] cnt;
   logic [6:0] shift;
   logic [6:0] addr;
   logic [6:0] addr_comb;
   logic [7:0] wdata_comb;
   logic [7:0] pre_byte;
   logic [7:0] cur_byte;

   function automatic logic mapped(input logic [6:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   function automatic logic [7:0] lookup(input logic [6:0] a);
      if (mapped(a)) return regs[a[IW-1:0]];
      return '0;
   endfunction

   // The eighth bit of each half is still on SPI_IN when it is consumed, so the
   // full address/data byte is formed from the shifter plus the live input.
   always_comb begin
      rise          = bus.SPI_CLK & ~clk_q & bus.SPI_EN;
      addr_comb     = {shift[5:0], bus.SPI_IN};
      wdata_comb    = {shift, bus.SPI_IN};
      pre_byte      = lookup(addr_comb);
      cur_byte      = lookup(addr);
      bus.usr_rdata = lookup(bus.usr_addr);
   end

   always_ff @(posedge FSM_Clk) begin
      if (reset) begin
         state         <= IDLE;
         clk_q         <= 1'b0;
         cnt           <= '0;
         shift         <= '0;
         mode          <= 1'b0;
         addr          <= '0;
         regs          <= '{default: INIT_VAL};
         bus.SPI_OUT   <= 1'b0;
         bus.wr_valid  <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
         bus.busy      <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         clk_q        <= bus.SPI_CLK;
         bus.wr_valid <= 1'b0;

         // User write first so a same-address SPI commit below overrides it.
         if (bus.usr_we && mapped(bus.usr_addr))
            regs[bus.usr_addr[IW-1:0]] <= bus.usr_wdata;

         case (state)
            IDLE: begin
               if (bus.SPI_EN) begin
                  state    <= ADDR;
                  bus.busy <= 1'b1;
                  cnt      <= '0;
                  shift    <= '0;
               end
            end
            ADDR, DATA: begin
               if (!bus.SPI_EN) begin
                  state         <= IDLE;
                  bus.busy      <= 1'b0;
                  bus.frame_err <= 1'b1;
                  bus.SPI_OUT   <= 1'b0;
               end else if (rise) begin
                  shift <= {shift[5:0], bus.SPI_IN};
                  cnt   <= cnt + 3'd1;
                  if (state == ADDR) begin
                     if (cnt == 3'd7) begin
                        mode        <= shift[6];
                        addr        <= addr_comb;
                        state       <= DATA;
                        bus.SPI_OUT <= ~shift[6] & pre_byte[7];
                     end
                  end else if (cnt == 3'd7) begin
                     state       <= DONE;
                     bus.SPI_OUT <= 1'b0;
                     if (mode) begin
                        if (mapped(addr))
                           regs[addr[IW-1:0]] <= wdata_comb;
                        bus.wr_valid <= 1'b1;
                        bus.wr_addr  <= addr;
                        bus.wr_data  <= wdata_comb;
                     end
                  end else begin
                     bus.SPI_OUT <= ~mode & cur_byte[3'd6 - cnt];
                  end
               end
            end
            DONE: begin
               if (!bus.SPI_EN) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_responder.sv
// Randomized scoreboard bench for spi_responder: a bus-level master drives
// frames, a passive monitor decodes SPI/wr_valid traffic against queued expectations.
module tb_spi_responder;
   localparam int unsigned NR = 100;
   localparam logic [7:0]  IV = 8'h3C;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_responder_if bus();

   spi_responder #(.NUM_REGS(NR), .INIT_VAL(IV)) dut (
      .FSM_Clk(clk),
      .reset  (rst),
      .bus    (bus)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0]  mem [128];
   bit          err_model;
   logic [14:0] exp_wr [$];
   logic [7:0]  exp_rd [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit mapped(input logic [6:0] a);
      return 32'(a) < NR;
   endfunction

   function automatic logic [7:0] model_rd(input logic [6:0] a);
      return mapped(a) ? mem[a] : 8'h00;
   endfunction

   task automatic model_reset();
      foreach (mem[i]) mem[i] = IV;
      err_model = 1'b0;
   endtask

   // Monitor: decodes each frame as the master sees it and checks reported writes.
   logic        m_prev_clk = 1'b0;
   logic        m_prev_en  = 1'b0;
   logic        m_prev_out = 1'b0;
   int          m_cnt = 0;
   logic [15:0] m_mosi = '0;
   logic [15:0] m_miso = '0;
   logic [14:0] m_e;

   always @(posedge clk) begin
      #1;
      if (bus.wr_valid) begin
         if (exp_wr.size() == 0) check("unexpected_wr_valid", 1, 0);
         else begin
            m_e = exp_wr.pop_front();
            check("wr_addr", 32'(bus.wr_addr), 32'(m_e[14:8]));
            check("wr_data", 32'(bus.wr_data), 32'(m_e[7:0]));
         end
      end
      if (bus.SPI_EN && !m_prev_en) m_cnt = 0;
      if (bus.SPI_EN && bus.SPI_CLK && !m_prev_clk) begin
         if (m_cnt < 16) begin
            m_mosi = {m_mosi[14:0], bus.SPI_IN};
            m_miso = {m_miso[14:0], m_prev_out};
         end
         m_cnt++;
      end
      if (!bus.SPI_EN && m_prev_en && m_cnt >= 16 && !m_mosi[15]) begin
         if (exp_rd.size() == 0) check("unexpected_read", 1, 0);
         else check("read_data", 32'(m_miso[7:0]), 32'(exp_rd.pop_front()));
      end
      m_prev_clk = bus.SPI_CLK;
      m_prev_en  = bus.SPI_EN;
      m_prev_out = bus.SPI_OUT;
   end

   task automatic check_reset_outputs();
      check("rst_spi_out",   32'(bus.SPI_OUT),   0);
      check("rst_wr_valid",  32'(bus.wr_valid),  0);
      check("rst_wr_addr",   32'(bus.wr_addr),   0);
      check("rst_wr_data",   32'(bus.wr_data),   0);
      check("rst_busy",      32'(bus.busy),      0);
      check("rst_frame_err", 32'(bus.frame_err), 0);
   endtask

   // kind: 0 full frame, 1 drop SPI_EN after nbits, 2 reset after nbits
   task automatic frame(input logic [15:0] w, input int nbits, input int kind, input int h,
                        input int extra, input bit coll, input logic [6:0] ca, input logic [7:0] cd);
      logic [6:0] a;
      logic [7:0] d;
      a = w[14:8];
      d = w[7:0];
      @(negedge clk);
      check("busy_idle", 32'(bus.busy), 0);
      bus.SPI_EN = 1'b1;
      if (kind == 0 && !w[15]) exp_rd.push_back(model_rd(a));
      @(negedge clk);
      check("busy_frame", 32'(bus.busy), 1);
      for (int i = 0; i < nbits + extra; i++) begin
         bus.SPI_IN = (i < 16) ? w[15-i] : 1'($urandom);
         repeat (h) @(negedge clk);
         bus.SPI_CLK = 1'b1;
         if (i == 15 && kind == 0) begin
            if (w[15]) exp_wr.push_back({a, d});
            if (coll) begin
               bus.usr_addr  = ca;
               bus.usr_wdata = cd;
               bus.usr_we    = 1'b1;
               if (mapped(ca)) mem[ca] = cd;
            end
            if (w[15] && mapped(a)) mem[a] = d;
         end
         @(negedge clk);
         bus.usr_we = 1'b0;
         repeat (h - 1) @(negedge clk);
         bus.SPI_CLK = 1'b0;
      end
      repeat (h) @(negedge clk);
      if (kind == 2) begin
         rst = 1'b1;
         bus.SPI_EN = 1'b0;
         @(negedge clk);
         check_reset_outputs();
         rst = 1'b0;
         model_reset();
      end else begin
         bus.SPI_EN = 1'b0;
         if (kind == 1) err_model = 1'b1;
         repeat (2) @(negedge clk);
         check("busy_end",      32'(bus.busy),      0);
         check("frame_err",     32'(bus.frame_err), 32'(err_model));
         check("spi_out_after", 32'(bus.SPI_OUT),   0);
      end
   endtask

   task automatic uwrite(input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.usr_addr  = a;
      bus.usr_wdata = d;
      bus.usr_we    = 1'b1;
      @(negedge clk);
      bus.usr_we = 1'b0;
      if (mapped(a)) mem[a] = d;
   endtask

   task automatic chk_rd(input logic [6:0] a);
      @(negedge clk);
      bus.usr_addr = a;
      #1;
      check($sformatf("usr_rdata[%0h]", a), 32'(bus.usr_rdata), 32'(model_rd(a)));
   endtask

   initial begin
      bus.SPI_EN    = 1'b0;
      bus.SPI_CLK   = 1'b0;
      bus.SPI_IN    = 1'b0;
      bus.usr_addr  = '0;
      bus.usr_we    = 1'b0;
      bus.usr_wdata = '0;
      model_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      chk_rd(7'h00);
      chk_rd(7'h63);
      chk_rd(7'h64);
      chk_rd(7'h7F);

      frame({1'b1, 7'h35, 8'hA7}, 16, 0, 1, 0, 1'b0, '0, '0);
      chk_rd(7'h35);
      uwrite(7'h12, 8'h5C);
      frame({1'b0, 7'h12, 8'h00}, 16, 0, 1, 0, 1'b0, '0, '0);
      frame({1'b1, 7'h7F, 8'h55}, 16, 0, 2, 1, 1'b0, '0, '0);
      frame({1'b0, 7'h7F, 8'h00}, 16, 0, 1, 0, 1'b0, '0, '0);
      chk_rd(7'h7F);
      frame({1'b1, 7'h20, 8'hFF}, 11, 1, 1, 0, 1'b0, '0, '0);
      chk_rd(7'h20);
      frame({1'b1, 7'h20, 8'h66}, 16, 0, 1, 0, 1'b0, '0, '0);
      chk_rd(7'h20);
      frame({1'b1, 7'h40, 8'h99}, 16, 0, 1, 0, 1'b1, 7'h40, 8'h11);
      chk_rd(7'h40);
      frame({1'b1, 7'h41, 8'h5A}, 16, 0, 3, 0, 1'b1, 7'h42, 8'h77);
      chk_rd(7'h41);
      chk_rd(7'h42);
      frame({1'b1, 7'h55, 8'hEE}, 12, 2, 1, 0, 1'b0, '0, '0);
      chk_rd(7'h55);
      chk_rd(7'h35);

      for (int n = 0; n < 60; n++) begin
         logic [15:0] w;
         logic [6:0]  ca;
         int r;
         int kind;
         int nb;
         w    = 16'($urandom);
         r    = $urandom_range(0, 19);
         kind = (r < 15) ? 0 : (r < 19) ? 1 : 2;
         nb   = (kind == 0) ? 16 : (kind == 1) ? $urandom_range(0, 15) : $urandom_range(1, 15);
         ca   = ($urandom_range(0, 1) == 1) ? w[14:8] : 7'($urandom);
         frame(w, nb, kind, $urandom_range(1, 3), (kind == 0) ? $urandom_range(0, 2) : 0,
               $urandom_range(0, 3) == 0, ca, 8'($urandom));
         if ($urandom_range(0, 2) == 0) uwrite(7'($urandom), 8'($urandom));
      end

      repeat (5) @(negedge clk);
      check("exp_wr_drained", 32'(exp_wr.size()), 0);
      check("exp_rd_drained", 32'(exp_rd.size()), 0);
      for (int a = 0; a < 128; a++) chk_rd(7'(a));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
